// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared encodings for the universal shift register sequencer
package usr_pkg;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_SHL  = 3'd1;
   localparam logic [2:0] OP_SHR  = 3'd2;
   localparam logic [2:0] OP_ROL  = 3'd3;
   localparam logic [2:0] OP_ROR  = 3'd4;
   localparam logic [2:0] OP_ASR  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_ASR;
   endfunction

endpackage

// File: rtl/usr_step_counter.sv
// rtl/usr_step_counter.sv - loadable down-counter with zero flag
module usr_step_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;

   // Saturates at zero so a stray decrement can never wrap the count.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && !zero) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/usr_shift_sequencer.sv
// rtl/usr_shift_sequencer.sv - expands shift commands into per-cycle USR controls
module usr_shift_sequencer
   import usr_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_fill,
   input  logic [WIDTH-1:0] usr_q,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] par_in,
   output logic             left_in,
   output logic             right_in,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           state_q, state_d;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] data_q;
   logic             fill_q;
   logic             accept;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt_load_val;
   logic             q_msb, q_lsb;

   assign accept = cmd_valid && (state_q == ST_IDLE);
   assign q_msb  = |(usr_q >> (WIDTH-1));
   assign q_lsb  = |(usr_q & WIDTH'(1));

   // Counter holds remaining steps minus one, so RUN ends on the zero flag.
   assign cnt_load_val = (cmd_op == OP_LOAD || cmd_cnt == '0) ? '0 : cmd_cnt - CNT_W'(1);

   usr_step_counter #(.CNT_W(CNT_W)) u_step_counter (
      .clk      (clk),
      .clr      (clr),
      .load     (accept),
      .load_val (cnt_load_val),
      .dec      (state_q == ST_RUN),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         data_q  <= '0;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            fill_q <= cmd_fill;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      sel      = SEL_HOLD;
      par_in   = '0;
      left_in  = 1'b0;
      right_in = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (op_legal(cmd_op) && (cmd_op == OP_LOAD || cmd_cnt != '0)) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (cnt_zero) begin
               state_d = ST_DONE;
            end
            case (op_q)
               OP_LOAD: begin sel = SEL_LOAD; par_in   = data_q; end
               OP_SHL:  begin sel = SEL_SHL;  left_in  = fill_q; end
               OP_SHR:  begin sel = SEL_SHR;  right_in = fill_q; end
               OP_ROL:  begin sel = SEL_SHL;  left_in  = q_msb;  end
               OP_ROR:  begin sel = SEL_SHR;  right_in = q_lsb;  end
               OP_ASR:  begin sel = SEL_SHR;  right_in = q_msb;  end
               default: sel = SEL_HOLD;
            endcase
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign err       = (state_q == ST_DONE) && !op_legal(op_q);

endmodule
